aes128_cipher_core: RTL and testbench



---
 rtl/aes_pkg.sv | 46 ++++
 rtl/aes_sbox_gf.sv | 37 +++
 rtl/aes128_cipher_core.sv | 89 ++++++++
 tb/tb_aes128_cipher_core.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 types and GF(2^8) helpers: state layout, rcon table, xtime, MixColumns column.
// Pure combinational functions, no latency, no flow control.
package aes_pkg;

  // Indexed [row][col]; bytes of a 128-bit block map column-major.
  typedef logic [3:0][3:0][7:0] state_t;

  localparam logic [7:0] RCON [16] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
    8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (8'h1b & {8{b[7]}});
  endfunction

  // col = {s0, s1, s2, s3}, top row in the MSBs.
  function automatic logic [31:0] mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic state_t to_state(input logic [127:0] v);
    state_t s;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        s[r][c] = v[127 - 8*(4*c + r) -: 8];
    return s;
  endfunction

  function automatic logic [127:0] from_state(input state_t s);
    logic [127:0] v;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        v[127 - 8*(4*c + r) -: 8] = s[r][c];
    return v;
  endfunction

endpackage

// File: rtl/aes_sbox_gf.sv
// Forward AES S-box: multiplicative inverse in GF(2^8) (as a^254) followed by the affine map.
// Purely combinational, no flow control.
module aes_sbox_gf
  import aes_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] s
);

  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = x;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

  logic [7:0] sq;
  logic [7:0] inv;

  // a^254 = a^2 * a^4 * ... * a^128; zero maps to zero as required.
  always_comb begin
    sq  = a;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
            ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end

endmodule

// File: rtl/aes128_cipher_core.sv
// Iterative AES-128 encryptor, one round per clock with on-the-fly key expansion.
// Result and done pulse 11 cycles after ld; ld restarts at any time, no backpressure.
module aes128_cipher_core
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         ld,
  input  logic [127:0] key,
  input  logic [127:0] text_in,
  output logic         done,
  output logic [127:0] text_out
);

  logic [127:0] text_in_r;
  state_t       sa;
  state_t       sb;
  state_t       sr;
  state_t       mc;
  state_t       rk;
  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  nw0, nw1, nw2, nw3;
  logic [31:0]  rot_w;
  logic [31:0]  sub_w;
  logic [3:0]   rcon_idx;
  logic [3:0]   dcnt;
  logic         ld_r;

  for (genvar r = 0; r < 4; r++) begin : g_row
    for (genvar c = 0; c < 4; c++) begin : g_col
      aes_sbox_gf u_sbox (.a(sa[r][c]), .s(sb[r][c]));
    end
  end

  assign rot_w = {w3[23:0], w3[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_kbox
    aes_sbox_gf u_sbox (.a(rot_w[8*i +: 8]), .s(sub_w[8*i +: 8]));
  end

  always_comb begin
    nw0 = w0 ^ sub_w ^ {RCON[rcon_idx], 24'h0};
    nw1 = nw0 ^ w1;
    nw2 = nw1 ^ w2;
    nw3 = nw2 ^ w3;
    rk  = to_state({w0, w1, w2, w3});
    sr  = '0;
    mc  = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        sr[r][c] = sb[r][2'(c + r)];
    for (int c = 0; c < 4; c++)
      {mc[0][c], mc[1][c], mc[2][c], mc[3][c]} = mix_col({sr[0][c], sr[1][c], sr[2][c], sr[3][c]});
  end

  // Key schedule and captured plaintext need no reset; ld always initialises them.
  always_ff @(posedge clk) begin
    if (ld) begin
      text_in_r <= text_in;
      {w0, w1, w2, w3} <= key;
    end else begin
      {w0, w1, w2, w3} <= {nw0, nw1, nw2, nw3};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dcnt     <= 4'd0;
      done     <= 1'b0;
      ld_r     <= 1'b0;
      text_out <= '0;
      rcon_idx <= 4'd0;
      sa       <= '0;
    end else begin
      ld_r <= ld;
      done <= (dcnt == 4'd1) && !ld;
      if (ld) begin
        rcon_idx <= 4'd0;
        dcnt     <= 4'd11;
      end else begin
        rcon_idx <= rcon_idx + 4'd1;
        if (dcnt != 4'd0) dcnt <= dcnt - 4'd1;
        if (dcnt == 4'd1) text_out <= from_state(sr) ^ {w0, w1, w2, w3};
      end
      sa <= ld_r ? to_state(text_in_r ^ {w0, w1, w2, w3}) : (mc ^ rk);
    end
  end

endmodule

// File: tb/tb_aes128_cipher_core.sv
// Bench for aes128_cipher_core: byte-array AES reference, cycle scoreboard, directed and random loads.
module tb_aes128_cipher_core;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         ld = 1'b0;
  logic [127:0] key = '0;
  logic [127:0] text_in = '0;
  logic         done;
  logic [127:0] text_out;

  aes128_cipher_core dut (
    .clk(clk), .rst(rst), .ld(ld), .key(key), .text_in(text_in),
    .done(done), .text_out(text_out)
  );

  always #5 clk = ~clk;

  localparam logic [127:0] C1_K = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_P = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_K  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_P  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_C  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] Z_C  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  // ---------------- reference model ----------------
  logic [7:0] sbox_tab [256];

  // Classic generator walk: p steps through powers of 3, q through powers of 3^-1.
  initial begin
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ (q << 1);
      q = q ^ (q << 2);
      q = q ^ (q << 4);
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]} ^ 8'h63;
      sbox_tab[p] = x;
    end while (p != 8'h01);
    sbox_tab[0] = 8'h63;
  end

  function automatic logic [7:0] dbl(input logic [7:0] b);
    return (b << 1) ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] round_key(input logic [127:0] k, input int n);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]], sbox_tab[t[31:24]]} ^ {rc, 24'h0};
        rc = dbl(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*n], w[4*n+1], w[4*n+2], w[4*n+3]};
  endfunction

  function automatic logic [127:0] aes_ref(input logic [127:0] k, input logic [127:0] p);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [127:0] v;
    logic [127:0] rkv;
    v = p ^ round_key(k, 0);
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) s[i] = sbox_tab[v[127 - 8*i -: 8]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          t[r + 4*c] = s[r + 4*((c + r) % 4)];
      if (rnd < 10) begin
        for (int c = 0; c < 4; c++) begin
          s[4*c]   = dbl(t[4*c]) ^ dbl(t[4*c+1]) ^ t[4*c+1] ^ t[4*c+2] ^ t[4*c+3];
          s[4*c+1] = t[4*c] ^ dbl(t[4*c+1]) ^ dbl(t[4*c+2]) ^ t[4*c+2] ^ t[4*c+3];
          s[4*c+2] = t[4*c] ^ t[4*c+1] ^ dbl(t[4*c+2]) ^ dbl(t[4*c+3]) ^ t[4*c+3];
          s[4*c+3] = dbl(t[4*c]) ^ t[4*c] ^ t[4*c+1] ^ t[4*c+2] ^ dbl(t[4*c+3]);
        end
      end else begin
        for (int i = 0; i < 16; i++) s[i] = t[i];
      end
      rkv = round_key(k, rnd);
      for (int i = 0; i < 16; i++) v[127 - 8*i -: 8] = s[i] ^ rkv[127 - 8*i -: 8];
    end
    return v;
  endfunction

  // Cycle-level expectation: a pending job completes 11 edges after its ld.
  logic         m_pend = 1'b0;
  int           m_cnt = 0;
  logic [127:0] m_val = '0;
  logic [127:0] m_rk10 = '0;
  logic         m_done = 1'b0;
  logic [127:0] m_out = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_pend = 1'b0;
      m_done = 1'b0;
      m_out  = '0;
    end else if (ld) begin
      m_pend = 1'b1;
      m_cnt  = 11;
      m_val  = aes_ref(key, text_in);
      m_rk10 = round_key(key, 10);
      m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_pend) begin
        m_cnt = m_cnt - 1;
        if (m_cnt == 0) begin
          m_pend = 1'b0;
          m_done = 1'b1;
          m_out  = m_val;
        end
      end
    end
  end

  // ---------------- compare ----------------
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_seen = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (cyc == 2) begin
      chk("ref_c1", aes_ref(C1_K, C1_P), C1_C);
      chk("ref_b", aes_ref(B_K, B_P), B_C);
      chk("ref_zero", aes_ref('0, '0), Z_C);
      chk("ref_b_rk10", round_key(B_K, 10), B_RK10);
    end
    if (cyc >= 2) begin
      chk("done", {127'd0, done}, {127'd0, m_done});
      chk("text_out", text_out, m_out);
      if (m_pend && m_cnt == 1)
        chk("round_key10", {dut.w0, dut.w1, dut.w2, dut.w3}, m_rk10);
      if (done) done_seen++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_ld(input logic [127:0] k, input logic [127:0] p);
    @(negedge clk);
    ld = 1'b1;
    key = k;
    text_in = p;
    @(negedge clk);
    ld = 1'b0;
  endtask

  initial begin
    idle(3);
    rst = 1'b0;
    idle(2);

    do_ld(C1_K, C1_P);
    idle(14);
    do_ld(B_K, B_P);
    idle(14);
    do_ld('0, '0);
    idle(14);

    // Restart after 5 cycles: only the second block completes.
    do_ld(B_K, B_P);
    idle(4);
    do_ld(C1_K, C1_P);
    idle(14);

    // Reset mid-run, then a fresh block.
    do_ld(B_K, B_P);
    idle(5);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    idle(14);
    do_ld(C1_K, C1_P);
    idle(14);

    // Back-to-back: next ld lands in the done cycle.
    do_ld(C1_K, C1_P);
    idle(10);
    do_ld(B_K, B_P);
    idle(14);

    // ld held high for several cycles.
    @(negedge clk);
    ld = 1'b1;
    key = B_K;
    text_in = C1_P;
    idle(4);
    ld = 1'b0;
    idle(14);

    for (int it = 0; it < 25; it++) begin
      do_ld({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
      if ($urandom_range(0, 3) == 0) begin
        idle($urandom_range(0, 9));
        do_ld({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
      end
      idle($urandom_range(10, 14));
    end
    idle(3);

    checks++;
    if (done_seen < 30) begin
      failures++;
      $display("FAIL done_count: got %0d pulses, required at least 30", done_seen);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
